// File: rtl/pico_ctrl_core.sv
// PicoCtrl execution core: single-cycle decode of the 16-bit ROM word, conditional
// immediate write to one of four output registers, or conditional jump.
module pico_ctrl_core #(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [7:0]        cond_in,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [7:0]        reg0,
   output logic [7:0]        reg1,
   output logic [7:0]        reg2,
   output logic [7:0]        reg3,
   output logic [3:0]        wr_strobe
);

   typedef enum logic [1:0] {
      ActWrite = 2'b00,
      ActJump  = 2'b01,
      ActRsvd2 = 2'b10,
      ActRsvd3 = 2'b11
   } action_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        regs_q [4];
   logic [7:0]        regs_d [4];
   logic [3:0]        strobe_q, strobe_d;
   logic [7:1]        sync_q [SYNC_STAGES];

   logic [2:0] cond_sel;
   logic       cond_val;
   action_e    action;
   logic [1:0] reg_sel;
   logic [7:0] imm;
   logic [7:0] cond_vec;
   logic       cond_true;

   // c0 is hard-wired low, so the bit-0 input never needs synchronizing.
   logic unused_cond0;
   assign unused_cond0 = cond_in[0];

   assign cond_sel  = rom_data[15:13];
   assign cond_val  = rom_data[12];
   assign action    = action_e'(rom_data[11:10]);
   assign reg_sel   = rom_data[9:8];
   assign imm       = rom_data[7:0];
   assign cond_vec  = {sync_q[SYNC_STAGES-1], 1'b0};
   assign cond_true = (cond_vec[cond_sel] == cond_val);

   always_comb begin
      pc_d     = pc_q;
      regs_d   = regs_q;
      strobe_d = 4'b0000;
      if (en) begin
         pc_d = pc_q + ADDR_W'(1);
         case (action)
            ActJump: begin
               if (cond_true) pc_d = imm[ADDR_W-1:0];
            end
            ActWrite: begin
               if (cond_true) begin
                  regs_d[reg_sel]   = imm;
                  strobe_d[reg_sel] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         strobe_q <= 4'b0000;
         for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      end else begin
         pc_q     <= pc_d;
         strobe_q <= strobe_d;
         regs_q   <= regs_d;
         // The synchronizer runs regardless of en so conditions stay current while stalled.
         sync_q[0] <= cond_in[7:1];
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign rom_addr  = pc_q;
   assign reg0      = regs_q[0];
   assign reg1      = regs_q[1];
   assign reg2      = regs_q[2];
   assign reg3      = regs_q[3];
   assign wr_strobe = strobe_q;

endmodule

// File: tb/tb_pico_ctrl_core.sv
// Bench for pico_ctrl_core: directed scenarios plus randomized programs, every cycle
// compared against an instruction-level reference model.
module tb_pico_ctrl_core;

   localparam int SYNC = 2;
   localparam int NPC  = 32;

   logic        clk;
   logic        reset;
   logic        en;
   logic [7:0]  cond_in;
   logic [4:0]  rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  reg0, reg1, reg2, reg3;
   logic [3:0]  wr_strobe;

   logic [15:0] rom [NPC];

   int tests = 0;
   int fails = 0;

   // Reference model state
   int         m_pc;
   logic [7:0] m_regs [4];
   logic [3:0] m_strobe;
   logic [7:0] m_hist [SYNC];

   pico_ctrl_core #(
      .ADDR_W      (5),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .cond_in   (cond_in),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .reg0      (reg0),
      .reg1      (reg1),
      .reg2      (reg2),
      .reg3      (reg3),
      .wr_strobe (wr_strobe)
   );

   assign rom_data = rom[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge of the architecture, written from the instruction semantics.
   task automatic model_edge();
      logic [15:0] ins;
      logic [7:0]  c;
      logic        t;
      if (reset) begin
         m_pc     = 0;
         m_strobe = 4'b0000;
         for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
         for (int i = 0; i < SYNC; i++) m_hist[i] = 8'h00;
      end else begin
         ins = rom[m_pc];
         c   = m_hist[SYNC-1];
         c[0] = 1'b0;
         t   = (c[ins[15:13]] == ins[12]);
         m_strobe = 4'b0000;
         if (en) begin
            if (ins[11:10] == 2'b01 && t) m_pc = int'(ins[4:0]);
            else m_pc = (m_pc + 1) % NPC;
            if (ins[11:10] == 2'b00 && t) begin
               m_regs[ins[9:8]] = ins[7:0];
               m_strobe = 4'b0001 << ins[9:8];
            end
         end
         for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = cond_in;
      end
   endtask

   task automatic check_model();
      chk("model_rom_addr", 32'(rom_addr), 32'(m_pc));
      chk("model_reg0", 32'(reg0), 32'(m_regs[0]));
      chk("model_reg1", 32'(reg1), 32'(m_regs[1]));
      chk("model_reg2", 32'(reg2), 32'(m_regs[2]));
      chk("model_reg3", 32'(reg3), 32'(m_regs[3]));
      chk("model_wr_strobe", 32'(wr_strobe), 32'(m_strobe));
   endtask

   task automatic step(input logic r, input logic e, input logic [7:0] c);
      reset   = r;
      en      = e;
      cond_in = c;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic fill_nop();
      for (int i = 0; i < NPC; i++) rom[i] = 16'h1000;
   endtask

   function automatic logic [15:0] rand_ins();
      logic [15:0] w;
      w = 16'($urandom);
      // Bias towards always-true conditions so writes and jumps actually happen.
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'b0000;
      if ($urandom_range(0, 3) != 0) w[11] = 1'b0;
      return w;
   endfunction

   initial begin
      logic [7:0]  cv;
      logic        v, cval;
      logic [15:0] enc [3];

      reset = 1'b1; en = 1'b0; cond_in = 8'h00;
      m_pc = 0; m_strobe = 4'b0000;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 8'h00;

      // Straight-line writes and PC wrap
      fill_nop();
      rom[0] = 16'h0101; rom[1] = 16'h02A5; rom[2] = 16'h033C;
      step(1'b1, 1'b0, 8'h00);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_regs", {reg3, reg2, reg1, reg0}, 32'h0);
      chk("rst_strobe", 32'(wr_strobe), 32'd0);
      step(1'b0, 1'b1, 8'h00);
      chk("sl_reg1", 32'(reg1), 32'h01);
      chk("sl_strobe1", 32'(wr_strobe), 32'b0010);
      step(1'b0, 1'b1, 8'h00);
      chk("sl_reg2", 32'(reg2), 32'hA5);
      chk("sl_strobe2", 32'(wr_strobe), 32'b0100);
      step(1'b0, 1'b1, 8'h00);
      chk("sl_reg3", 32'(reg3), 32'h3C);
      chk("sl_strobe3", 32'(wr_strobe), 32'b1000);
      step(1'b0, 1'b1, 8'h00);
      chk("sl_strobe_idle", 32'(wr_strobe), 32'd0);
      for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 8'h00);
      chk("sl_wrap_addr", 32'(rom_addr), 32'd0);
      step(1'b0, 1'b1, 8'h00);
      chk("sl_wrap_strobe", 32'(wr_strobe), 32'b0010);

      // Wait loop on c1
      fill_nop();
      rom[0] = 16'h0101; rom[1] = 16'h3401; rom[2] = 16'h0102;
      step(1'b1, 1'b0, 8'h02);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h02);
      step(1'b0, 1'b1, 8'h02);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 8'h02);
         chk("wait_hold", 32'(rom_addr), 32'd1);
      end
      step(1'b0, 1'b1, 8'h00);
      chk("wait_drop_t1", 32'(rom_addr), 32'd1);
      step(1'b0, 1'b1, 8'h00);
      chk("wait_drop_t2", 32'(rom_addr), 32'd1);
      step(1'b0, 1'b1, 8'h00);
      chk("wait_drop_t3", 32'(rom_addr), 32'd2);
      step(1'b0, 1'b1, 8'h00);
      chk("wait_reg1", 32'(reg1), 32'h02);

      // Condition polarity and bit select; c0 immune to cond_in[0]
      for (int k = 1; k < 8; k++) begin
         for (int taken = 0; taken < 2; taken++) begin
            v    = 1'($urandom_range(0, 1));
            cval = (taken != 0) ? v : ~v;
            cv   = 8'($urandom);
            cv[k] = v;
            cv[0] = 1'b1;
            fill_nop();
            rom[2] = {3'd0, 1'b0, 2'b00, 2'b00, 8'(k)};
            rom[4] = {3'(k), cval, 2'b01, 2'b00, 8'h10};
            step(1'b1, 1'b0, cv);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, cv);
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, cv);
            chk("pol_c0_write", 32'(reg0), 32'(k));
            chk("pol_at4", 32'(rom_addr), 32'd4);
            step(1'b0, 1'b1, cv);
            chk("pol_next", 32'(rom_addr), (taken != 0) ? 32'd16 : 32'd5);
         end
      end

      // Reserved actions and canonical nop
      enc[0] = 16'h0955; enc[1] = 16'h0EAA; enc[2] = 16'h1000;
      for (int j = 0; j < 3; j++) begin
         fill_nop();
         rom[0] = 16'h0111; rom[1] = 16'h0222; rom[6] = enc[j];
         step(1'b1, 1'b0, 8'h00);
         for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);
         chk("rsv_at6", 32'(rom_addr), 32'd6);
         step(1'b0, 1'b1, 8'h00);
         chk("rsv_addr", 32'(rom_addr), 32'd7);
         chk("rsv_strobe", 32'(wr_strobe), 32'd0);
         chk("rsv_regs", {reg3, reg2, reg1, reg0}, 32'h0022_1100);
      end

      // en gating with a pending write to reg0
      fill_nop();
      rom[0] = 16'h0133; rom[1] = 16'h0077;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      chk("en_pre_strobe", 32'(wr_strobe), 32'b0010);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 8'h00);
         chk("en_off_addr", 32'(rom_addr), 32'd1);
         chk("en_off_reg0", 32'(reg0), 32'h00);
         chk("en_off_strobe", 32'(wr_strobe), 32'd0);
      end
      step(1'b0, 1'b1, 8'h00);
      chk("en_on_reg0", 32'(reg0), 32'h77);
      chk("en_on_strobe", 32'(wr_strobe), 32'b0001);
      step(1'b0, 1'b1, 8'h00);
      chk("en_on_strobe_end", 32'(wr_strobe), 32'd0);

      // Reset while parked in a wait loop
      fill_nop();
      rom[0] = 16'h02FF; rom[9] = 16'h3409;
      step(1'b1, 1'b0, 8'h02);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h02);
      for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 8'h02);
      chk("mr_parked", 32'(rom_addr), 32'd9);
      chk("mr_reg2", 32'(reg2), 32'hFF);
      step(1'b1, 1'b1, 8'h02);
      chk("mr_addr", 32'(rom_addr), 32'd0);
      chk("mr_regs", {reg3, reg2, reg1, reg0}, 32'h0);
      chk("mr_strobe", 32'(wr_strobe), 32'd0);
      step(1'b0, 1'b1, 8'h02);
      chk("mr_restart_reg2", 32'(reg2), 32'hFF);
      chk("mr_restart_strobe", 32'(wr_strobe), 32'b0100);

      // Randomized programs, conditions, enables and occasional resets
      for (int i = 0; i < NPC; i++) rom[i] = rand_ins();
      cv = 8'($urandom);
      for (int n = 0; n < 1500; n++) begin
         if (n % 250 == 249) for (int i = 0; i < NPC; i++) rom[i] = rand_ins();
         if ($urandom_range(0, 3) == 0) cv = 8'($urandom);
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), cv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
